// File: rtl/rect_draw.sv
// Rectangle rasteriser: walks an axis-aligned rectangle (filled or 1-pixel outline),
// clipped to the visible area, and offers one pixel per cycle on a valid/ready handshake.
module rect_draw #(
  parameter int CW   = 8,
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  input  logic [CW-1:0]   x0,
  input  logic [CW-1:0]   y0,
  input  logic [CW-1:0]   x1,
  input  logic [CW-1:0]   y1,
  input  logic            abort,
  input  logic            pixel_ready,
  output logic [CW-1:0]   x_out,
  output logic [CW-1:0]   y_out,
  output logic            pixel_valid,
  output logic            busy,
  output logic            done,
  output logic [2*CW-1:0] pix_count
);

  // Visible limits expressed in coordinate width; a limit beyond the coordinate range saturates.
  localparam logic [CW-1:0] XLIM = (XMAX >= (2**CW)) ? {CW{1'b1}} : CW'(XMAX);
  localparam logic [CW-1:0] YLIM = (YMAX >= (2**CW)) ? {CW{1'b1}} : CW'(YMAX);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_DRAW   = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     ax_q, ay_q, bx_q, by_q;
  logic              mode_q;
  logic [CW-1:0]     min_x_q, max_x_q, min_y_q, max_y_q;
  logic [CW-1:0]     vis_xmax_q, vis_ymax_q;
  logic [CW-1:0]     x_q, y_q;
  logic              valid_q, busy_q, done_q;
  logic [2*CW-1:0]   cnt_q;

  logic [CW-1:0]     min_x_s, max_x_s, min_y_s, max_y_s;
  logic [CW-1:0]     vis_xmax_s, vis_ymax_s;
  logic              empty_s;
  logic              mid_row_s, jump_ok_s;
  logic [CW-1:0]     next_x_d, next_y_d;
  logic              last_d;

  // Bounding box and clipped limits derived from the latched corners.
  always_comb begin
    min_x_s    = (ax_q <= bx_q) ? ax_q : bx_q;
    max_x_s    = (ax_q <= bx_q) ? bx_q : ax_q;
    min_y_s    = (ay_q <= by_q) ? ay_q : by_q;
    max_y_s    = (ay_q <= by_q) ? by_q : ay_q;
    vis_xmax_s = (max_x_s > XLIM) ? XLIM : max_x_s;
    vis_ymax_s = (max_y_s > YLIM) ? YLIM : max_y_s;
    empty_s    = (min_x_s > XLIM) || (min_y_s > YLIM);
  end

  // Next raster position after the current pixel; edges use the unclipped bounds,
  // and every row ends by equality so counters never wrap.
  always_comb begin
    next_x_d  = x_q;
    next_y_d  = y_q;
    last_d    = 1'b0;
    mid_row_s = mode_q && (y_q > min_y_q) && (y_q < max_y_q);
    jump_ok_s = (max_x_q <= XLIM) && (max_x_q > min_x_q);
    if (mid_row_s && (x_q == min_x_q) && jump_ok_s) begin
      next_x_d = max_x_q;
    end else if (mid_row_s || (x_q == vis_xmax_q)) begin
      if (y_q == vis_ymax_q) begin
        last_d = 1'b1;
      end else begin
        next_x_d = min_x_q;
        next_y_d = y_q + ONE;
      end
    end else begin
      next_x_d = x_q + ONE;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ax_q       <= '0;
      ay_q       <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      mode_q     <= 1'b0;
      min_x_q    <= '0;
      max_x_q    <= '0;
      min_y_q    <= '0;
      max_y_q    <= '0;
      vis_xmax_q <= '0;
      vis_ymax_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q  <= 1'b0;
          valid_q <= 1'b0;
          if (start) begin
            ax_q    <= x0;
            ay_q    <= y0;
            bx_q    <= x1;
            by_q    <= y1;
            mode_q  <= mode;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_SETUP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SETUP: begin
          if (abort) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            min_x_q    <= min_x_s;
            max_x_q    <= max_x_s;
            min_y_q    <= min_y_s;
            max_y_q    <= max_y_s;
            vis_xmax_q <= vis_xmax_s;
            vis_ymax_q <= vis_ymax_s;
            x_q        <= min_x_s;
            y_q        <= min_y_s;
            if (empty_s) begin
              valid_q <= 1'b0;
              state_q <= S_FINISH;
            end else begin
              valid_q <= 1'b1;
              state_q <= S_DRAW;
            end
          end
        end
        S_DRAW: begin
          if (abort) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (valid_q && pixel_ready) begin
            cnt_q <= cnt_q + (2*CW)'(1);
            if (last_d) begin
              valid_q <= 1'b0;
              state_q <= S_FINISH;
            end else begin
              x_q     <= next_x_d;
              y_q     <= next_y_d;
              state_q <= S_DRAW;
            end
          end else begin
            state_q <= S_DRAW;
          end
        end
        S_FINISH: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          done_q  <= abort ? 1'b0 : 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign pixel_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pix_count   = cnt_q;

endmodule

// File: tb/tb_rect_draw.sv
// Directed bench for rect_draw: a table of rectangles with hand-computed pixel lists,
// plus short sequences for back-pressure, abort, start+abort and mid-draw reset.
module tb_rect_draw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_a, start_b, mode, abort, pixel_ready;
  logic [7:0] x0, y0, x1, y1;

  logic [7:0]  xa, ya, xb, yb;
  logic        va, ba, da, vb, bb, db;
  logic [15:0] ca, cb;

  rect_draw dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .abort(abort), .pixel_ready(pixel_ready),
    .x_out(xa), .y_out(ya), .pixel_valid(va), .busy(ba), .done(da), .pix_count(ca)
  );

  rect_draw #(.CW(8), .XMAX(255), .YMAX(255)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .abort(abort), .pixel_ready(pixel_ready),
    .x_out(xb), .y_out(yb), .pixel_valid(vb), .busy(bb), .done(db), .pix_count(cb)
  );

  logic        sel;
  logic [7:0]  xo, yo;
  logic        vo, bo, dn;
  logic [15:0] co;

  always_comb begin
    xo = sel ? xb : xa;
    yo = sel ? yb : ya;
    vo = sel ? vb : va;
    bo = sel ? bb : ba;
    dn = sel ? db : da;
    co = sel ? cb : ca;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sel;
    logic [7:0] x0, y0, x1, y1;
    logic       mode;
    int         n;
  } vec_t;

  localparam int NV = 9;
  vec_t        vecs [0:NV-1];
  logic [15:0] ex   [0:NV-1][0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic setv(input int i, input logic s, input int ax, input int ay,
                      input int bx, input int by, input logic m);
    vecs[i].sel  = s;
    vecs[i].x0   = ax[7:0];
    vecs[i].y0   = ay[7:0];
    vecs[i].x1   = bx[7:0];
    vecs[i].y1   = by[7:0];
    vecs[i].mode = m;
    vecs[i].n    = 0;
  endtask

  task automatic addp(input int i, input int x, input int y);
    ex[i][vecs[i].n] = {x[7:0], y[7:0]};
    vecs[i].n = vecs[i].n + 1;
  endtask

  task automatic launch(input logic s, input int ax, input int ay, input int bx,
                        input int by, input logic m);
    @(negedge clk);
    sel  = s;
    x0   = ax[7:0];
    y0   = ay[7:0];
    x1   = bx[7:0];
    y1   = by[7:0];
    mode = m;
    if (s) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int  k;
    bit  got_done;
    pixel_ready = 1'b1;
    abort       = 1'b0;
    launch(vecs[i].sel, int'(vecs[i].x0), int'(vecs[i].y0), int'(vecs[i].x1),
           int'(vecs[i].y1), vecs[i].mode);
    k = 0;
    got_done = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      @(negedge clk);
      if (vo) begin
        if (k < vecs[i].n) begin
          chk($sformatf("v%0d pixel%0d xy", i, k), {16'h0, xo, yo}, {16'h0, ex[i][k]});
        end
        chk($sformatf("v%0d pixel%0d cycle", i, k), c, k);
        k++;
      end
      if (dn) begin
        got_done = 1'b1;
        chk($sformatf("v%0d done cycle", i), c, vecs[i].n + 1);
        chk($sformatf("v%0d pix_count", i), {16'h0, co}, vecs[i].n);
        chk($sformatf("v%0d busy at done", i), {31'h0, bo}, 32'd0);
      end
    end
    chk($sformatf("v%0d done seen", i), {31'h0, got_done}, 32'd1);
    chk($sformatf("v%0d pixel total", i), k, vecs[i].n);
    @(negedge clk);
    chk($sformatf("v%0d done single", i), {31'h0, dn}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; mode = 1'b0; abort = 1'b0; pixel_ready = 1'b1;
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd0; y1 = 8'd0;
    sel = 1'b0;

    // Expected pixel lists, worked out by hand.
    setv(0, 1'b1, 254, 255, 255, 255, 1'b0);
    addp(0, 254, 255); addp(0, 255, 255);
    setv(1, 1'b0, 2, 3, 4, 1, 1'b0);
    for (int y = 1; y <= 3; y++) for (int x = 2; x <= 4; x++) addp(1, x, y);
    setv(2, 1'b0, 10, 10, 13, 12, 1'b1);
    for (int x = 10; x <= 13; x++) addp(2, x, 10);
    addp(2, 10, 11); addp(2, 13, 11);
    for (int x = 10; x <= 13; x++) addp(2, x, 12);
    setv(3, 1'b0, 158, 118, 200, 130, 1'b0);
    addp(3, 158, 118); addp(3, 159, 118); addp(3, 158, 119); addp(3, 159, 119);
    setv(4, 1'b0, 170, 5, 180, 9, 1'b0);
    setv(5, 1'b0, 6, 8, 5, 5, 1'b1);
    for (int y = 5; y <= 8; y++) begin addp(5, 5, y); addp(5, 6, y); end
    setv(6, 1'b0, 7, 4, 7, 2, 1'b1);
    addp(6, 7, 2); addp(6, 7, 3); addp(6, 7, 4);
    setv(7, 1'b0, 157, 0, 170, 2, 1'b1);
    addp(7, 157, 0); addp(7, 158, 0); addp(7, 159, 0);
    addp(7, 157, 1);
    addp(7, 157, 2); addp(7, 158, 2); addp(7, 159, 2);
    setv(8, 1'b0, 0, 118, 2, 125, 1'b1);
    addp(8, 0, 118); addp(8, 1, 118); addp(8, 2, 118);
    addp(8, 0, 119); addp(8, 2, 119);

    #1;
    chk("reset x_out", {24'h0, xa}, 32'd0);
    chk("reset y_out", {24'h0, ya}, 32'd0);
    chk("reset valid", {31'h0, va}, 32'd0);
    chk("reset busy", {31'h0, ba}, 32'd0);
    chk("reset done", {31'h0, da}, 32'd0);
    chk("reset pix_count", {16'h0, ca}, 32'd0);
    chk("reset busy b", {31'h0, bb}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Back-pressure: first pixel held while pixel_ready is low for three cycles.
    pixel_ready = 1'b0;
    launch(1'b0, 0, 0, 1, 0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("hold valid c%0d", c), {31'h0, vo}, 32'd1);
      chk($sformatf("hold xy c%0d", c), {16'h0, xo, yo}, 32'h0000);
      chk($sformatf("hold count c%0d", c), {16'h0, co}, 32'd0);
      if (c == 3) pixel_ready = 1'b1;
    end
    @(negedge clk);
    chk("hold second xy", {16'h0, xo, yo}, 32'h0100);
    chk("hold second valid", {31'h0, vo}, 32'd1);
    chk("hold count one", {16'h0, co}, 32'd1);
    @(negedge clk);
    chk("hold finish valid", {31'h0, vo}, 32'd0);
    @(negedge clk);
    chk("hold done", {31'h0, dn}, 32'd1);
    chk("hold pix_count", {16'h0, co}, 32'd2);

    // Abort after five accepted pixels of a 4x4 fill, colliding with an acceptance.
    launch(1'b0, 0, 0, 3, 3, 1'b0);
    repeat (6) @(negedge clk);
    chk("abort pre count", {16'h0, co}, 32'd5);
    chk("abort pre xy", {16'h0, xo, yo}, 32'h0101);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort valid", {31'h0, vo}, 32'd0);
    chk("abort busy", {31'h0, bo}, 32'd0);
    chk("abort done", {31'h0, dn}, 32'd0);
    chk("abort pix_count", {16'h0, co}, 32'd5);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("abort idle done c%0d", c), {31'h0, dn}, 32'd0);
      chk($sformatf("abort idle valid c%0d", c), {31'h0, vo}, 32'd0);
    end

    // start and abort together in IDLE still start the rectangle.
    @(negedge clk);
    sel = 1'b0; x0 = 8'd1; y0 = 8'd1; x1 = 8'd1; y1 = 8'd1; mode = 1'b1;
    start_a = 1'b1; abort = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("sa valid", {31'h0, vo}, 32'd1);
    chk("sa xy", {16'h0, xo, yo}, 32'h0101);
    chk("sa busy", {31'h0, bo}, 32'd1);
    @(negedge clk);
    chk("sa finish valid", {31'h0, vo}, 32'd0);
    @(negedge clk);
    chk("sa done", {31'h0, dn}, 32'd1);
    chk("sa pix_count", {16'h0, co}, 32'd1);

    // Reset in the middle of a rectangle clears outputs without a clock edge.
    launch(1'b0, 0, 0, 3, 3, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid busy before reset", {31'h0, bo}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset x", {24'h0, xa}, 32'd0);
    chk("mid reset y", {24'h0, ya}, 32'd0);
    chk("mid reset valid", {31'h0, va}, 32'd0);
    chk("mid reset busy", {31'h0, ba}, 32'd0);
    chk("mid reset done", {31'h0, da}, 32'd0);
    chk("mid reset count", {16'h0, ca}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("post reset idle valid c%0d", c), {31'h0, vo}, 32'd0);
      chk($sformatf("post reset idle busy c%0d", c), {31'h0, bo}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
